// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB with I/D-cache stalls and a
// memory timeout. Define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_main_fsm #(
  parameter int OPCODE_W   = 7,
  parameter int IMM_SRC_W  = 3,
  parameter int MEM_TO_MAX = 255,
  parameter int TO_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 imemReady,
  input  logic                 dmemReady,
  output logic                 imemRead,
  output logic                 irWrite,
  output logic                 pcWrite,
  output logic [1:0]           aluOP,
  output logic [1:0]           resultSrc,
  output logic [1:0]           aluSrcA,
  output logic                 aluSrcB,
  output logic [IMM_SRC_W-1:0] immSrc,
  output logic                 branch,
  output logic                 jump,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic                 memError,
  output logic                 illegalInstr,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_B     = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR  = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_AUIPC = OPCODE_W'(7'b0010111);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(7'b0110111);

  localparam logic [IMM_SRC_W-1:0] IMM_I = IMM_SRC_W'(3'b000);
  localparam logic [IMM_SRC_W-1:0] IMM_S = IMM_SRC_W'(3'b001);
  localparam logic [IMM_SRC_W-1:0] IMM_B = IMM_SRC_W'(3'b010);
  localparam logic [IMM_SRC_W-1:0] IMM_J = IMM_SRC_W'(3'b011);
  localparam logic [IMM_SRC_W-1:0] IMM_U = IMM_SRC_W'(3'b100);

  localparam logic [TO_CNT_W-1:0] TO_MAX = TO_CNT_W'(MEM_TO_MAX);
  localparam bit                  TO_EN  = (MEM_TO_MAX != 0);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                mem_err_q, mem_err_d;
`ifdef ILLEGAL_TRAP_EN
  logic                ill_q, ill_d;
`endif

  logic [1:0]           dec_aluop, dec_srca;
  logic                 dec_srcb;
  logic [IMM_SRC_W-1:0] dec_imm;
  logic                 is_load, is_store, is_b, is_jmp, to_hit, op_legal;

  logic                 imem_read, ir_write, pc_write, br, jmp, mem_read, mem_write, reg_write;
  logic [1:0]           alu_op, res_src, src_a;
  logic                 src_b;
  logic [IMM_SRC_W-1:0] imm_src;

  // Datapath controls of the latched opcode, identical to the single-cycle decoder table
  always_comb begin
    dec_aluop = 2'b00;
    dec_srca  = 2'b00;
    dec_srcb  = 1'b0;
    dec_imm   = IMM_I;
    case (opc_q)
      OP_R:     dec_aluop = 2'b10;
      OP_I:     begin dec_aluop = 2'b10; dec_srcb = 1'b1; end
      OP_LOAD:  dec_srcb = 1'b1;
      OP_STORE: begin dec_srcb = 1'b1; dec_imm = IMM_S; end
      OP_B:     begin dec_aluop = 2'b01; dec_imm = IMM_B; end
      OP_JAL:   begin dec_srca = 2'b10; dec_srcb = 1'b1; dec_imm = IMM_J; end
      OP_JALR:  dec_srcb = 1'b1;
      OP_AUIPC: begin dec_srca = 2'b10; dec_srcb = 1'b1; dec_imm = IMM_U; end
      OP_LUI:   begin dec_srca = 2'b01; dec_srcb = 1'b1; dec_imm = IMM_U; end
      default:  ;
    endcase
  end

  assign is_load  = (opc_q == OP_LOAD);
  assign is_store = (opc_q == OP_STORE);
  assign is_b     = (opc_q == OP_B);
  assign is_jmp   = (opc_q == OP_JAL) || (opc_q == OP_JALR);
  assign to_hit   = TO_EN && (cnt_q == TO_MAX);
  assign op_legal = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_B,
                                   OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    cnt_d     = '0;
    mem_err_d = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    ill_d     = ill_q;
`endif
    imem_read = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    br        = 1'b0;
    jmp       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    res_src   = 2'b00;
    src_a     = 2'b00;
    src_b     = 1'b0;
    imm_src   = IMM_I;
    case (state_q)
      S_FETCH: begin
        imem_read = 1'b1;
        if (imemReady) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (to_hit) begin
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          ill_d   = 1'b1;
          state_d = S_TRAP;
`else
          pc_write = 1'b1;
          state_d  = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_op  = dec_aluop;
        src_a   = dec_srca;
        src_b   = dec_srcb;
        imm_src = dec_imm;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_b) begin
          br       = 1'b1;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = dec_aluop;
        src_a     = dec_srca;
        src_b     = dec_srcb;
        imm_src   = dec_imm;
        mem_read  = is_load;
        mem_write = is_store;
        // Ready in the timeout cycle completes the transfer rather than flagging an error
        if (dmemReady) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (to_hit) begin
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + TO_CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        jmp       = is_jmp;
        res_src   = is_load ? 2'b01 : (is_jmp ? 2'b10 : 2'b00);
        state_d   = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ill_q <= 1'b0;
    else        ill_q <= ill_d;
  end
  assign illegalInstr = ill_q;
`else
  assign illegalInstr = 1'b0;
`endif

  // The reset state is FETCH, so controls are forced low while rst_n is asserted
  assign imemRead  = rst_n & imem_read;
  assign irWrite   = rst_n & ir_write;
  assign pcWrite   = rst_n & pc_write;
  assign branch    = rst_n & br;
  assign jump      = rst_n & jmp;
  assign memRead   = rst_n & mem_read;
  assign memWrite  = rst_n & mem_write;
  assign regWrite  = rst_n & reg_write;
  assign aluOP     = rst_n ? alu_op  : 2'b00;
  assign resultSrc = rst_n ? res_src : 2'b00;
  assign aluSrcA   = rst_n ? src_a   : 2'b00;
  assign aluSrcB   = rst_n & src_b;
  assign immSrc    = rst_n ? imm_src : '0;
  assign memError  = mem_err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: randomized instructions and cache stalls, with
// expected per-instruction behaviour computed from the instruction-level timing rules.
`timescale 1ns/1ps
module tb_multicycle_main_fsm;

  localparam int TO_MAX = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       imemReady, dmemReady;
  logic       imemRead, irWrite, pcWrite, aluSrcB, branch, jump;
  logic       memRead, memWrite, regWrite, memError, illegalInstr;
  logic [1:0] aluOP, resultSrc, aluSrcA;
  logic [2:0] immSrc, state;

  multicycle_main_fsm #(.OPCODE_W(7), .IMM_SRC_W(3), .MEM_TO_MAX(TO_MAX), .TO_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemRead(imemRead), .irWrite(irWrite), .pcWrite(pcWrite), .aluOP(aluOP),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc),
    .branch(branch), .jump(jump), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .memError(memError), .illegalInstr(illegalInstr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opc;
    int         fs;
    int         ms;
  } plan_t;

  typedef struct {
    logic [6:0] opc;
    int         fs;
    int         ms;
    int         cycles;
    int         pcw;
    int         regw;
    int         memr;
    int         memw;
    int         br;
    int         jmp;
    logic [1:0] rs;
    logic       legal;
    logic [1:0] aluop;
    logic [1:0] srca;
    logic       srcb;
    logic [2:0] imm;
    logic       merr;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  model_merr = 1'b0;
  bit    mon_en = 1'b0;
  bit    phase_go = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Instruction-level reference: cycle counts and strobe totals from the latency rules
  function automatic exp_t model(input logic [6:0] opc, input int fs, input int ms,
                                 input logic merr_in);
    exp_t e;
    bit   tout;
    int   mc;
    e = '{default: 0};
    tout    = (ms > TO_MAX);
    mc      = tout ? TO_MAX + 1 : ms + 1;
    e.opc   = opc;
    e.fs    = fs;
    e.ms    = ms;
    e.legal = 1'b1;
    e.merr  = merr_in;
    e.cycles = fs + 2;
    case (opc)
      OP_R:     begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.aluop = 2'b10; end
      OP_I:     begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.aluop = 2'b10; e.srcb = 1'b1; end
      OP_AUIPC: begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.srca = 2'b10; e.srcb = 1'b1; e.imm = 3'b100; end
      OP_LUI:   begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.srca = 2'b01; e.srcb = 1'b1; e.imm = 3'b100; end
      OP_JAL:   begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.jmp = 1; e.rs = 2'b10;
                      e.srca = 2'b10; e.srcb = 1'b1; e.imm = 3'b011; end
      OP_JALR:  begin e.cycles += 2; e.regw = 1; e.pcw = 1; e.jmp = 1; e.rs = 2'b10; e.srcb = 1'b1; end
      OP_B:     begin e.cycles += 1; e.pcw = 1; e.br = 1; e.aluop = 2'b01; e.imm = 3'b010; end
      OP_LOAD:  begin
        e.cycles += 1 + mc + (tout ? 0 : 1);
        e.memr = mc; e.regw = tout ? 0 : 1; e.pcw = e.regw; e.rs = 2'b01; e.srcb = 1'b1;
        e.merr = merr_in | tout;
      end
      OP_STORE: begin
        e.cycles += 1 + mc;
        e.memw = mc; e.pcw = tout ? 0 : 1; e.srcb = 1'b1; e.imm = 3'b001;
        e.merr = merr_in | tout;
      end
      default:  begin e.legal = 1'b0; e.pcw = 1; end
    endcase
    return e;
  endfunction

  task automatic add_plan(input logic [6:0] opc, input int fs, input int ms);
    exp_t  e;
    plan_t p;
    e = model(opc, fs, ms, model_merr);
    model_merr = e.merr;
    p.opc = opc; p.fs = fs; p.ms = ms;
    plan_q.push_back(p);
    exp_q.push_back(e);
  endtask

  // Driver: directed reset/timeout sequence, then a cache responder serving the plan queue
  initial begin
    plan_t cur;
    bit    have_plan;
    int    fwait, mwait, nwr;
    have_plan = 0; fwait = 0; mwait = 0; nwr = 0;
    rst_n = 1'b0; imemReady = 1'b0; dmemReady = 1'b0; opcode = 7'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_controls", 32'({imemRead, irWrite, pcWrite, aluOP, resultSrc, aluSrcA, aluSrcB,
                             immSrc, branch, jump, memRead, memWrite, regWrite}), 32'd0);
    chk("rst_memError", 32'(memError), 32'd0);
    chk("rst_illegalInstr", 32'(illegalInstr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; opcode = OP_STORE; imemReady = 1'b1;
    @(negedge clk);
    imemReady = 1'b0; dmemReady = 1'b0;
    for (int c = 0; c < 10 && state != 3'd3; c++) @(negedge clk);
    chk("store_reaches_mem", 32'(state), 32'd3);
    @(negedge clk);
    chk("store_stall_memWrite", 32'(memWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midmem_reset_state", 32'(state), 32'd0);
    chk("midmem_reset_controls", 32'({imemRead, irWrite, pcWrite, aluOP, resultSrc, aluSrcA,
                                      aluSrcB, immSrc, branch, jump, memRead, memWrite,
                                      regWrite}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; dmemReady = 1'b1;
    repeat (4) begin @(negedge clk); if (memWrite) nwr++; end
    chk("fetch_timeout_not_yet", 32'(memError), 32'd0);
    @(negedge clk); if (memWrite) nwr++;
    chk("fetch_timeout_hit", 32'(memError), 32'd1);
    repeat (3) begin @(negedge clk); if (memWrite) nwr++; end
    chk("no_memWrite_after_reset", 32'(nwr), 32'd0);
    chk("fetch_timeout_state", 32'(state), 32'd0);
    rst_n = 1'b0;
    #1 chk("reset_clears_memError", 32'(memError), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    mon_en = 1'b1; phase_go = 1'b1;
    forever begin
      @(negedge clk);
      if (imemRead) begin
        if (!have_plan && plan_q.size() > 0) begin
          cur = plan_q.pop_front(); have_plan = 1; fwait = cur.fs; mwait = cur.ms;
        end
        if (have_plan && fwait == 0) begin
          imemReady = 1'b1; opcode = cur.opc; have_plan = 0;
        end else begin
          imemReady = 1'b0;
          if (have_plan) fwait--;
        end
      end else begin
        imemReady = 1'($urandom_range(0, 1));
      end
      if (memRead || memWrite) begin
        dmemReady = (mwait == 0);
        if (mwait > 0) mwait--;
      end else begin
        dmemReady = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: an instruction window opens each time FETCH is entered
  bit         win_open = 0;
  logic [2:0] prev_state = 3'd0;
  int         w_cyc, w_irw, w_pcw, w_regw, w_memr, w_memw, w_br, w_jmp, ntx = 0;
  logic [1:0] w_rs, w_aluop, w_srca;
  logic       w_srcb, w_exec;
  logic [2:0] w_imm;

  task automatic close_win();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_txn: got an instruction window, required none pending");
    end else begin
      e = exp_q.pop_front();
      ntx++;
      $display("txn %0d opc=%b fs=%0d ms=%0d cycles=%0d pcw=%0d regw=%0d memr=%0d memw=%0d memError=%0d",
               ntx, e.opc, e.fs, e.ms, w_cyc, w_pcw, w_regw, w_memr, w_memw, memError);
      chk("cycles", 32'(w_cyc), 32'(e.cycles));
      chk("irWrite_count", 32'(w_irw), 32'd1);
      chk("pcWrite_count", 32'(w_pcw), 32'(e.pcw));
      chk("regWrite_count", 32'(w_regw), 32'(e.regw));
      chk("memRead_cycles", 32'(w_memr), 32'(e.memr));
      chk("memWrite_cycles", 32'(w_memw), 32'(e.memw));
      chk("branch_pulses", 32'(w_br), 32'(e.br));
      chk("jump_pulses", 32'(w_jmp), 32'(e.jmp));
      chk("exec_seen", 32'(w_exec), 32'(e.legal));
      chk("memError", 32'(memError), 32'(e.merr));
      if (e.legal) begin
        chk("exec_aluOP", 32'(w_aluop), 32'(e.aluop));
        chk("exec_aluSrcA", 32'(w_srca), 32'(e.srca));
        chk("exec_aluSrcB", 32'(w_srcb), 32'(e.srcb));
        chk("exec_immSrc", 32'(w_imm), 32'(e.imm));
      end
      if (e.regw != 0) chk("wb_resultSrc", 32'(w_rs), 32'(e.rs));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (state == 3'd0 && (!win_open || prev_state != 3'd0)) begin
        if (win_open) close_win();
        win_open = 1;
        w_cyc = 0; w_irw = 0; w_pcw = 0; w_regw = 0; w_memr = 0; w_memw = 0;
        w_br = 0; w_jmp = 0; w_exec = 1'b0; w_rs = 2'b11;
        w_aluop = 2'b11; w_srca = 2'b11; w_srcb = 1'b0; w_imm = 3'b111;
      end
      if (win_open) begin
        w_cyc++;
        if (irWrite) w_irw++;
        if (pcWrite) w_pcw++;
        if (regWrite) begin w_regw++; w_rs = resultSrc; end
        if (memRead) w_memr++;
        if (memWrite) w_memw++;
        if (branch && pcWrite) w_br++;
        if (jump && pcWrite) w_jmp++;
        if (state == 3'd2) begin
          w_exec = 1'b1; w_aluop = aluOP; w_srca = aluSrcA; w_srcb = aluSrcB; w_imm = immSrc;
        end
      end
      prev_state = state;
    end
  end

  // Stimulus and end-of-run control
  initial begin
    logic [6:0] ops[9];
    logic [6:0] opc;
    int         k;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_B, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
    add_plan(OP_R, 0, 0);
    add_plan(OP_I, 4, 0);
    add_plan(OP_LOAD, 0, 3);
    add_plan(OP_STORE, 1, 0);
    add_plan(OP_STORE, 0, 4);
    add_plan(OP_LOAD, 0, 4);
    add_plan(OP_B, 2, 0);
    add_plan(OP_JAL, 0, 0);
    add_plan(OP_LOAD, 0, 20);
    for (int i = 0; i < 60; i++) begin
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 10);
`endif
      opc = (k < 9) ? ops[k] : ((k == 9) ? OP_BAD : 7'b0001111);
      add_plan(opc, $urandom_range(0, 4), $urandom_range(0, 6));
    end
`ifdef ILLEGAL_TRAP_EN
    begin
      plan_t p;
      p.opc = OP_BAD; p.fs = 0; p.ms = 0;
      plan_q.push_back(p);
    end
`else
    add_plan(OP_BAD, 0, 0);
`endif
    wait (phase_go);
    for (int c = 0; c < 30000 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d instructions pending, required 0", exp_q.size());
    end
    repeat (8) @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    chk("trap_state", 32'(state), 32'd5);
    chk("trap_illegalInstr", 32'(illegalInstr), 32'd1);
    chk("trap_strobes", 32'({imemRead, irWrite, pcWrite, regWrite, memRead, memWrite}), 32'd0);
`else
    chk("illegalInstr_tied_low", 32'(illegalInstr), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
